flight_cmd_scheduler: RTL and testbench
=======================================

Name: flight_cmd_scheduler

Overview:
Sits between frame_decoder and the flight controller (altitude PID / attitude mixer) and decides when decoded frames reach it. It sequences arming, gates live commands, and runs a link-loss failsafe. The failsafe first holds altitude with neutral attitude, then ramps the altitude command down to 0 and disarms. All downstream setpoints and gains come only from this block.

Parameters:
TIMEOUT_CYCLES, 32'd2500000, clk cycles without a frame before link is declared lost (50 ms @ 50 MHz)
ARM_FRAMES, 8, consecutive frames with ch1==0 required to arm
HOLD_CYCLES, 32'd50000000, cycles spent in HOLD before landing starts
RAMP_DIV, 32'd2500000, cycles per 1-LSB decrement of alt_cmd during LAND
NEUTRAL, 8'd128, neutral value for CH2..CH4

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_valid  in  1  one-cycle pulse from frame_decoder; ch/off inputs are valid in the same cycle
ch1..ch4  in  8 each  decoded CH1 (alt command) .. CH4
off1..off4  in  8 each  decoded OFF1 (alt_kp) .. OFF4
cmd_valid  out  1  one-cycle pulse: outputs below were updated
alt_cmd  out  8  altitude setpoint
roll_cmd, pitch_cmd, yaw_cmd  out  8 each  attitude setpoints (CH2..CH4)
gain1..gain4  out  8 each  gains (OFF1..OFF4)
armed  out  1  high in ACTIVE, HOLD, LAND
link_ok  out  1  low while the watchdog is expired
state  out  3  FSM state, for debug

Behaviour:
- Reset is asynchronous and active-high. It applies immediately, regardless of clk.
- Reset values: state=DISARMED, alt_cmd=0, roll/pitch/yaw=NEUTRAL, gain1=16, gain2..4=128, cmd_valid=0, armed=0, link_ok=0. All internal counters are 0.
- Watchdog:
  - Counter wd clears on frame_valid; otherwise it increments and saturates at TIMEOUT_CYCLES.
  - link_ok = (wd < TIMEOUT_CYCLES), registered.
  - Timeout event is a single cycle when wd transitions to TIMEOUT_CYCLES.
  - If frame_valid and the timeout event occur in the same cycle, frame_valid wins and there is no timeout.
- Latency: a frame accepted in cycle N updates the outputs and asserts cmd_valid in cycle N+1.
- FSM encoding: DISARMED=0, ARMING=1, ACTIVE=2, HOLD=3, LAND=4. Undefined codes go to DISARMED and apply the reset output values.
- DISARMED:
  - Outputs are held at their reset values; frames are not forwarded.
  - A frame with ch1==0 moves to ARMING with arm_cnt=1.
  - A frame with ch1!=0 is ignored.
- ARMING:
  - Frame with ch1==0: arm_cnt+1. When arm_cnt reaches ARM_FRAMES, go to ACTIVE, clear arm_cnt, and latch that frame (cmd_valid pulses).
  - Frame with ch1!=0: back to DISARMED, arm_cnt=0.
  - Timeout: back to DISARMED, arm_cnt=0.
  - ARM_FRAMES=1 arms on the first ch1==0 frame, going straight from DISARMED to ACTIVE.
  - The decoder's post-reset default pulse (ch1=0) counts as a frame.
- ACTIVE:
  - Every frame latches ch1..4 and off1..4 to the outputs and pulses cmd_valid.
  - Timeout: go to HOLD with hold_cnt=0. Set roll/pitch/yaw=NEUTRAL; keep alt_cmd and gains; pulse cmd_valid.
- HOLD:
  - hold_cnt increments every cycle.
  - A frame returns to ACTIVE and is latched normally; hold_cnt is cleared.
  - hold_cnt==HOLD_CYCLES-1 with no frame: go to LAND with ramp_cnt=0.
- LAND:
  - Frames are ignored; recovery requires a full disarm and re-arm.
  - ramp_cnt counts to RAMP_DIV-1 and wraps. On each wrap, alt_cmd decrements by 1, saturating at 0, and cmd_valid pulses.
  - When alt_cmd==0 (including on entry), go to DISARMED and apply the reset output values. Gains are retained across disarm and are not reset.
- armed is registered and follows the next state, so it changes in the same cycle as state.
- Counters are 32-bit unsigned. Overflow is not possible because every counter saturates or wraps before its maximum value.

Test Plan:
Bench parameters: TIMEOUT_CYCLES=100, ARM_FRAMES=4, HOLD_CYCLES=50, RAMP_DIV=4.
- Reset mid-ARMING (after 2 frames with ch1=0), deasserted between clk edges → outputs return to reset values immediately. Four more ch1=0 frames are then needed to reach ACTIVE.
- 4 frames with ch1=0, gap 10 cycles → state=ACTIVE after the 4th frame plus 1 cycle, cmd_valid pulse, armed=1. A 5th frame {ch1=40, ch2=130, off1=20} → alt_cmd=40, roll=130, gain1=20 one cycle later.
- ARMING with 3 ch1=0 frames, then a ch1=50 frame → DISARMED, alt_cmd stays 0, no cmd_valid.
- ACTIVE with alt_cmd=40, roll=200, no frames for 100 cycles → HOLD, link_ok=0, roll=128, alt_cmd=40. A frame at hold_cnt=20 → ACTIVE, link_ok=1.
- No frames after entering HOLD → LAND after 50 cycles. alt_cmd drops by 1 every 4 cycles (40 pulses total), then state=DISARMED, armed=0. A frame arriving during LAND has no effect.
- ACTIVE with frame_valid in the exact timeout cycle → stays ACTIVE, the frame is latched, link_ok stays 1.

Source files
------------

// File: rtl/flight_cmd_scheduler.sv
// Command scheduler between frame_decoder and the flight controller: arming sequence,
// live-command gating and a link-loss failsafe that holds altitude, then lands and disarms.
module flight_cmd_scheduler #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2500000,
    parameter int unsigned ARM_FRAMES     = 8,
    parameter logic [31:0] HOLD_CYCLES    = 32'd50000000,
    parameter logic [31:0] RAMP_DIV       = 32'd2500000,
    parameter logic [7:0]  NEUTRAL        = 8'd128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [7:0] ch1,
    input  logic [7:0] ch2,
    input  logic [7:0] ch3,
    input  logic [7:0] ch4,
    input  logic [7:0] off1,
    input  logic [7:0] off2,
    input  logic [7:0] off3,
    input  logic [7:0] off4,
    output logic       cmd_valid,
    output logic [7:0] alt_cmd,
    output logic [7:0] roll_cmd,
    output logic [7:0] pitch_cmd,
    output logic [7:0] yaw_cmd,
    output logic [7:0] gain1,
    output logic [7:0] gain2,
    output logic [7:0] gain3,
    output logic [7:0] gain4,
    output logic       armed,
    output logic       link_ok,
    output logic [2:0] state
);

    localparam logic [31:0] ARM_LAST = 32'(ARM_FRAMES);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMING   = 3'd1,
        S_ACTIVE   = 3'd2,
        S_HOLD     = 3'd3,
        S_LAND     = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] alt;
        logic [7:0] roll;
        logic [7:0] pitch;
        logic [7:0] yaw;
        logic [7:0] g1;
        logic [7:0] g2;
        logic [7:0] g3;
        logic [7:0] g4;
    } setpoints_t;

    localparam setpoints_t RST_OUT = '{alt: 8'd0, roll: NEUTRAL, pitch: NEUTRAL, yaw: NEUTRAL,
                                       g1: 8'd16, g2: 8'd128, g3: 8'd128, g4: 8'd128};

    state_t     st;
    setpoints_t sp;
    setpoints_t frame_c;
    logic [31:0] wd;
    logic [31:0] wd_next_c;
    logic [31:0] arm_cnt;
    logic [31:0] hold_cnt;
    logic [31:0] ramp_cnt;
    logic        timeout_c;
    logic        zero_ch1_c;

    assign frame_c    = {ch1, ch2, ch3, ch4, off1, off2, off3, off4};
    assign zero_ch1_c = (ch1 == 8'd0);

    // Watchdog: frames clear it, otherwise it saturates at the timeout value.
    assign wd_next_c = frame_valid ? 32'd0 :
                       (wd == TIMEOUT_CYCLES) ? wd : wd + 32'd1;
    assign timeout_c = !frame_valid && (wd != TIMEOUT_CYCLES) && (wd_next_c == TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd      <= 32'd0;
            link_ok <= 1'b0;
        end else begin
            wd      <= wd_next_c;
            link_ok <= (wd_next_c < TIMEOUT_CYCLES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= S_DISARMED;
            sp        <= RST_OUT;
            cmd_valid <= 1'b0;
            armed     <= 1'b0;
            arm_cnt   <= 32'd0;
            hold_cnt  <= 32'd0;
            ramp_cnt  <= 32'd0;
        end else begin
            cmd_valid <= 1'b0;
            case (st)
                S_DISARMED: begin
                    if (frame_valid && zero_ch1_c) begin
                        if (ARM_LAST == 32'd1) begin
                            st        <= S_ACTIVE;
                            armed     <= 1'b1;
                            sp        <= frame_c;
                            cmd_valid <= 1'b1;
                            arm_cnt   <= 32'd0;
                        end else begin
                            st      <= S_ARMING;
                            arm_cnt <= 32'd1;
                        end
                    end
                end
                S_ARMING: begin
                    if (frame_valid) begin
                        if (!zero_ch1_c) begin
                            st      <= S_DISARMED;
                            arm_cnt <= 32'd0;
                        end else if (arm_cnt + 32'd1 == ARM_LAST) begin
                            st        <= S_ACTIVE;
                            armed     <= 1'b1;
                            sp        <= frame_c;
                            cmd_valid <= 1'b1;
                            arm_cnt   <= 32'd0;
                        end else begin
                            arm_cnt <= arm_cnt + 32'd1;
                        end
                    end else if (timeout_c) begin
                        st      <= S_DISARMED;
                        arm_cnt <= 32'd0;
                    end
                end
                S_ACTIVE: begin
                    if (frame_valid) begin
                        sp        <= frame_c;
                        cmd_valid <= 1'b1;
                    end else if (timeout_c) begin
                        // Link lost: keep altitude and gains, level the attitude.
                        st        <= S_HOLD;
                        hold_cnt  <= 32'd0;
                        sp.roll   <= NEUTRAL;
                        sp.pitch  <= NEUTRAL;
                        sp.yaw    <= NEUTRAL;
                        cmd_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (frame_valid) begin
                        st        <= S_ACTIVE;
                        sp        <= frame_c;
                        cmd_valid <= 1'b1;
                        hold_cnt  <= 32'd0;
                    end else if (hold_cnt == HOLD_CYCLES - 32'd1) begin
                        st       <= S_LAND;
                        hold_cnt <= 32'd0;
                        ramp_cnt <= 32'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                S_LAND: begin
                    if (sp.alt == 8'd0) begin
                        // Touchdown: back to safe outputs, but gains survive the disarm.
                        st       <= S_DISARMED;
                        armed    <= 1'b0;
                        sp.alt   <= RST_OUT.alt;
                        sp.roll  <= RST_OUT.roll;
                        sp.pitch <= RST_OUT.pitch;
                        sp.yaw   <= RST_OUT.yaw;
                        ramp_cnt <= 32'd0;
                    end else if (ramp_cnt == RAMP_DIV - 32'd1) begin
                        ramp_cnt  <= 32'd0;
                        sp.alt    <= sp.alt - 8'd1;
                        cmd_valid <= 1'b1;
                    end else begin
                        ramp_cnt <= ramp_cnt + 32'd1;
                    end
                end
                default: begin
                    st       <= S_DISARMED;
                    sp       <= RST_OUT;
                    armed    <= 1'b0;
                    arm_cnt  <= 32'd0;
                    hold_cnt <= 32'd0;
                    ramp_cnt <= 32'd0;
                end
            endcase
        end
    end

    assign state     = st;
    assign alt_cmd   = sp.alt;
    assign roll_cmd  = sp.roll;
    assign pitch_cmd = sp.pitch;
    assign yaw_cmd   = sp.yaw;
    assign gain1     = sp.g1;
    assign gain2     = sp.g2;
    assign gain3     = sp.g3;
    assign gain4     = sp.g4;

endmodule

// File: tb/tb_flight_cmd_scheduler.sv
// Directed bench for flight_cmd_scheduler: arming, gating, hold/land failsafe and reset.
module tb_flight_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_valid;
    logic [7:0] ch1, ch2, ch3, ch4, off1, off2, off3, off4;
    logic       cmd_valid;
    logic [7:0] alt_cmd, roll_cmd, pitch_cmd, yaw_cmd;
    logic [7:0] gain1, gain2, gain3, gain4;
    logic       armed, link_ok;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    flight_cmd_scheduler #(
        .TIMEOUT_CYCLES(32'd100),
        .ARM_FRAMES    (4),
        .HOLD_CYCLES   (32'd50),
        .RAMP_DIV      (32'd4),
        .NEUTRAL       (8'd128)
    ) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid),
        .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
        .off1(off1), .off2(off2), .off3(off3), .off4(off4),
        .cmd_valid(cmd_valid), .alt_cmd(alt_cmd), .roll_cmd(roll_cmd),
        .pitch_cmd(pitch_cmd), .yaw_cmd(yaw_cmd),
        .gain1(gain1), .gain2(gain2), .gain3(gain3), .gain4(gain4),
        .armed(armed), .link_ok(link_ok), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle frame pulse; returns just after the capturing edge.
    task automatic send(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                        input logic [7:0] c4, input logic [7:0] o1, input logic [7:0] o2,
                        input logic [7:0] o3, input logic [7:0] o4);
        ch1 = c1; ch2 = c2; ch3 = c3; ch4 = c4;
        off1 = o1; off2 = o2; off3 = o3; off4 = o4;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic arm_frame();
        send(8'd0, 8'd100, 8'd110, 8'd120, 8'd30, 8'd31, 8'd32, 8'd33);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int pulses;
        int cyc;
        reset = 1'b1;
        frame_valid = 1'b0;
        {ch1, ch2, ch3, ch4, off1, off2, off3, off4} = '0;
        #20;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_alt", 32'(alt_cmd), 32'd0);
        chk("rst_roll", 32'(roll_cmd), 32'd128);
        chk("rst_yaw", 32'(yaw_cmd), 32'd128);
        chk("rst_gain1", 32'(gain1), 32'd16);
        chk("rst_gain4", 32'(gain4), 32'd128);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_link_ok", 32'(link_ok), 32'd0);
        #3 reset = 1'b0;
        tick();
        chk("link_up", 32'(link_ok), 32'd1);

        // Non-zero ch1 while disarmed is ignored.
        send(8'd70, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
        chk("dis_ignore_state", 32'(state), 32'd0);
        chk("dis_ignore_cv", 32'(cmd_valid), 32'd0);
        chk("dis_ignore_roll", 32'(roll_cmd), 32'd128);
        idle(10);

        // Reset in the middle of arming, asserted and released between edges.
        arm_frame(); idle(10);
        arm_frame();
        chk("arming_state", 32'(state), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_link", 32'(link_ok), 32'd0);
        #2 reset = 1'b0;
        idle(10);

        // Counter must restart: three frames keep it arming, the fourth arms.
        for (int i = 0; i < 3; i++) begin arm_frame(); idle(10); end
        chk("arm3_state", 32'(state), 32'd1);
        chk("arm3_roll", 32'(roll_cmd), 32'd128);
        chk("arm3_armed", 32'(armed), 32'd0);
        arm_frame();
        chk("arm4_state", 32'(state), 32'd2);
        chk("arm4_cv", 32'(cmd_valid), 32'd1);
        chk("arm4_armed", 32'(armed), 32'd1);
        chk("arm4_roll", 32'(roll_cmd), 32'd100);
        chk("arm4_yaw", 32'(yaw_cmd), 32'd120);
        chk("arm4_gain4", 32'(gain4), 32'd33);
        tick();
        chk("arm4_cv_pulse", 32'(cmd_valid), 32'd0);
        idle(5);

        send(8'd40, 8'd130, 8'd128, 8'd128, 8'd20, 8'd31, 8'd32, 8'd33);
        chk("f5_alt", 32'(alt_cmd), 32'd40);
        chk("f5_roll", 32'(roll_cmd), 32'd130);
        chk("f5_gain1", 32'(gain1), 32'd20);
        chk("f5_cv", 32'(cmd_valid), 32'd1);

        // Link loss: 100 silent cycles enter HOLD.
        send(8'd40, 8'd200, 8'd50, 8'd60, 8'd21, 8'd31, 8'd32, 8'd33);
        chk("b_roll", 32'(roll_cmd), 32'd200);
        idle(99);
        chk("b_pre_state", 32'(state), 32'd2);
        chk("b_pre_link", 32'(link_ok), 32'd1);
        tick();
        chk("hold_state", 32'(state), 32'd3);
        chk("hold_link", 32'(link_ok), 32'd0);
        chk("hold_roll", 32'(roll_cmd), 32'd128);
        chk("hold_pitch", 32'(pitch_cmd), 32'd128);
        chk("hold_alt", 32'(alt_cmd), 32'd40);
        chk("hold_gain1", 32'(gain1), 32'd21);
        chk("hold_cv", 32'(cmd_valid), 32'd1);
        chk("hold_armed", 32'(armed), 32'd1);
        idle(20);
        send(8'd40, 8'd200, 8'd50, 8'd60, 8'd21, 8'd31, 8'd32, 8'd33);
        chk("recover_state", 32'(state), 32'd2);
        chk("recover_link", 32'(link_ok), 32'd1);
        chk("recover_roll", 32'(roll_cmd), 32'd200);
        chk("recover_cv", 32'(cmd_valid), 32'd1);

        // Frame exactly in the would-be timeout cycle wins.
        idle(99);
        send(8'd40, 8'd60, 8'd70, 8'd80, 8'd22, 8'd31, 8'd32, 8'd33);
        chk("race_state", 32'(state), 32'd2);
        chk("race_link", 32'(link_ok), 32'd1);
        chk("race_roll", 32'(roll_cmd), 32'd60);
        chk("race_gain1", 32'(gain1), 32'd22);
        idle(99);
        chk("race_still_active", 32'(state), 32'd2);
        tick();
        chk("race_hold_state", 32'(state), 32'd3);
        chk("race_hold_roll", 32'(roll_cmd), 32'd128);

        // Silent HOLD lasts 50 cycles, then LAND ramps alt down every 4 cycles.
        idle(49);
        chk("hold_end_state", 32'(state), 32'd3);
        tick();
        chk("land_state", 32'(state), 32'd4);
        chk("land_armed", 32'(armed), 32'd1);
        chk("land_alt0", 32'(alt_cmd), 32'd40);
        idle(3);
        chk("land_alt_pre", 32'(alt_cmd), 32'd40);
        chk("land_cv_pre", 32'(cmd_valid), 32'd0);
        tick();
        chk("land_alt_dec", 32'(alt_cmd), 32'd39);
        chk("land_cv_dec", 32'(cmd_valid), 32'd1);
        send(8'd0, 8'd10, 8'd10, 8'd10, 8'd99, 8'd99, 8'd99, 8'd99);
        chk("land_frame_state", 32'(state), 32'd4);
        chk("land_frame_alt", 32'(alt_cmd), 32'd39);
        chk("land_frame_roll", 32'(roll_cmd), 32'd128);
        chk("land_frame_cv", 32'(cmd_valid), 32'd0);
        pulses = 1;
        cyc = 0;
        while (state == 3'd4 && cyc < 400) begin
            tick();
            cyc++;
            if (cmd_valid) pulses++;
        end
        chk("land_cycles", 32'(cyc), 32'd156);
        chk("land_pulses", 32'(pulses), 32'd40);
        chk("land_done_state", 32'(state), 32'd0);
        chk("land_done_armed", 32'(armed), 32'd0);
        chk("land_done_alt", 32'(alt_cmd), 32'd0);
        chk("land_done_roll", 32'(roll_cmd), 32'd128);
        chk("land_done_gain1", 32'(gain1), 32'd22);
        idle(5);

        // Aborted arming: a non-zero ch1 frame drops back to DISARMED.
        for (int i = 0; i < 3; i++) begin arm_frame(); idle(10); end
        chk("abort_pre_state", 32'(state), 32'd1);
        send(8'd50, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_alt", 32'(alt_cmd), 32'd0);
        chk("abort_cv", 32'(cmd_valid), 32'd0);
        idle(5);

        // Timeout while arming also disarms.
        arm_frame();
        chk("arm_to_pre", 32'(state), 32'd1);
        idle(99);
        chk("arm_to_wait", 32'(state), 32'd1);
        tick();
        chk("arm_to_state", 32'(state), 32'd0);
        chk("arm_to_link", 32'(link_ok), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
